// File: rtl/nexus_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nexus_sched_pkg
// Purpose  : Shared widths, pop-FSM state encoding and bucket-index split
//            helpers for the Nexus PIFO bucket scheduler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nexus_sched_pkg;

    localparam int BUCKET_W = 8;
    localparam int L1_W     = 4;
    localparam int L2_W     = 4;
    localparam int L1_SIZE  = 16;
    localparam int L2_SIZE  = 16;
    localparam int BUCKETS  = L1_SIZE * L2_SIZE;
    localparam int CNT_W    = 8;
    localparam int TOT_W    = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_COMMIT = 2'd2
    } sched_state_t;

    // Upper nibble of a bucket index: L1 bit / L2 row.
    function automatic logic [L1_W-1:0] l1_of(input logic [BUCKET_W-1:0] b);
        return b[BUCKET_W-1:L2_W];
    endfunction

    // Lower nibble of a bucket index: bit within the L2 row.
    function automatic logic [L2_W-1:0] l2_of(input logic [BUCKET_W-1:0] b);
        return b[L2_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/nexus_ffo16.sv
`default_nettype none
// ============================================================================
// Module   : nexus_ffo16
// Purpose  : 16-bit lowest-index first-one finder.
// Ports    : vec   in  16  input bitmap
//            idx   out 4   index of lowest set bit (15 when vec is zero)
//            valid out 1   vec has at least one bit set
// Revision : 1.0 - initial release
// ============================================================================
module nexus_ffo16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = 4'd15;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign valid = |vec;

endmodule
`default_nettype wire

// File: rtl/nexus_bucket_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nexus_bucket_sched_ctrl
// Purpose  : Occupancy counters and two-level (16x16) bitmap for 256 PIFO
//            buckets, with a 3-state pop FSM returning the lowest-index
//            non-empty bucket.
// Ports    : i_clk, i_arst_n           clock, async active-low reset
//            i_push_valid/_bucket      push request / bucket to increment
//            o_push_ready              push accepted (bucket not saturated)
//            i_pop_req, o_pop_ready    pop request / FSM idle
//            o_pop_valid/_empty/_bucket one-cycle pop result
//            o_empty, o_total          all-empty flag / total occupancy
// Revision : 1.0 - initial release
// ============================================================================
module nexus_bucket_sched_ctrl
    import nexus_sched_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_arst_n,
    input  logic                i_push_valid,
    input  logic [BUCKET_W-1:0] i_push_bucket,
    output logic                o_push_ready,
    input  logic                i_pop_req,
    output logic                o_pop_ready,
    output logic                o_pop_valid,
    output logic                o_pop_empty,
    output logic [BUCKET_W-1:0] o_pop_bucket,
    output logic                o_empty,
    output logic [TOT_W-1:0]    o_total
);

    logic [CNT_W-1:0]   count  [BUCKETS];
    logic [L1_SIZE-1:0] l1_map;
    logic [L2_SIZE-1:0] l2_map [L1_SIZE];

    sched_state_t       state, state_nxt;
    logic [L1_W-1:0]    sel_l1;
    logic               any_l1;

    logic [L1_W-1:0]    l1_idx;
    logic               l1_valid;
    logic [L2_W-1:0]    sel_l2;
    logic               l2_valid;
    logic [L2_SIZE-1:0] sel_row;
    logic [L2_SIZE-1:0] sel_l2_onehot;
    logic [BUCKET_W-1:0] pop_b;

    logic push_fire, pop_fire, same_b, drain, row_drain;

    nexus_ffo16 u_ffo_l1 (.vec(l1_map),  .idx(l1_idx), .valid(l1_valid));
    nexus_ffo16 u_ffo_l2 (.vec(sel_row), .idx(sel_l2), .valid(l2_valid));

    assign sel_row       = l2_map[sel_l1];
    assign sel_l2_onehot = L2_SIZE'(1) << sel_l2;
    assign pop_b         = {sel_l1, sel_l2};

    assign o_push_ready = (count[i_push_bucket] != CNT_MAX);
    assign o_empty      = ~|l1_map;

    assign push_fire = i_push_valid & o_push_ready;
    // Row sel_l1 cannot empty after SEARCH, so l2_valid only confirms any_l1.
    assign pop_fire  = (state == ST_COMMIT) & any_l1 & l2_valid;
    // Push and pop on the same bucket cancel: count and bits untouched.
    assign same_b    = push_fire & pop_fire & (i_push_bucket == pop_b);
    assign drain     = pop_fire & ~same_b & (count[pop_b] == CNT_W'(1));
    assign row_drain = drain & ((sel_row & ~sel_l2_onehot) == '0);

    // ---------------- pop FSM ----------------
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_pop_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                o_pop_ready = 1'b1;
                if (i_pop_req) begin
                    state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // L1 choice is frozen in SEARCH; the L2 choice is made live in COMMIT.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sel_l1 <= '0;
            any_l1 <= 1'b0;
        end else if (state == ST_SEARCH) begin
            sel_l1 <= l1_idx;
            any_l1 <= l1_valid;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_pop_valid  <= 1'b0;
            o_pop_empty  <= 1'b0;
            o_pop_bucket <= '0;
        end else begin
            o_pop_valid  <= (state == ST_COMMIT);
            o_pop_empty  <= (state == ST_COMMIT) & ~pop_fire;
            o_pop_bucket <= pop_fire ? pop_b : '0;
        end
    end

    // ---------------- counters and bitmaps ----------------
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < BUCKETS; i++) begin
                count[i] <= '0;
            end
        end else if (!same_b) begin
            if (pop_fire) begin
                count[pop_b] <= count[pop_b] - CNT_W'(1);
            end
            if (push_fire) begin
                count[i_push_bucket] <= count[i_push_bucket] + CNT_W'(1);
            end
        end
    end

    // Clears are written before sets so a push into the draining row keeps
    // its L1 bit.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            l1_map <= '0;
            for (int i = 0; i < L1_SIZE; i++) begin
                l2_map[i] <= '0;
            end
        end else begin
            if (drain) begin
                l2_map[sel_l1][sel_l2] <= 1'b0;
            end
            if (row_drain) begin
                l1_map[sel_l1] <= 1'b0;
            end
            if (push_fire) begin
                l2_map[l1_of(i_push_bucket)][l2_of(i_push_bucket)] <= 1'b1;
                l1_map[l1_of(i_push_bucket)]                       <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_total <= '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10:   o_total <= o_total + TOT_W'(1);
                2'b01:   o_total <= o_total - TOT_W'(1);
                default: o_total <= o_total;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nexus_bucket_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nexus_bucket_sched_ctrl
// Purpose  : Self-checking bench for nexus_bucket_sched_ctrl. A reference
//            model keeps per-bucket counts in a plain array and derives the
//            pop result by searching for the lowest non-empty bucket.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nexus_bucket_sched_ctrl;

    logic        clk;
    logic        arst_n;
    logic        push_valid;
    logic [7:0]  push_bucket;
    logic        push_ready;
    logic        pop_req;
    logic        pop_ready;
    logic        pop_valid;
    logic        pop_empty;
    logic [7:0]  pop_bucket;
    logic        empty;
    logic [15:0] total;

    nexus_bucket_sched_ctrl dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_push_valid (push_valid),
        .i_push_bucket(push_bucket),
        .o_push_ready (push_ready),
        .i_pop_req    (pop_req),
        .o_pop_ready  (pop_ready),
        .o_pop_valid  (pop_valid),
        .o_pop_empty  (pop_empty),
        .o_pop_bucket (pop_bucket),
        .o_empty      (empty),
        .o_total      (total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int         mcnt [256];
    int         mphase;      // 0 idle, 1 search, 2 commit
    int         snap_g;
    bit         snap_any;
    logic       e_valid;
    logic       e_empty;
    logic [7:0] e_bucket;
    logic [7:0] got [$];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_total();
        int s = 0;
        for (int b = 0; b < 256; b++) s += mcnt[b];
        return s;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 256; b++) mcnt[b] = 0;
        mphase   = 0;
        snap_any = 1'b0;
        snap_g   = 0;
        e_valid  = 1'b0;
        e_empty  = 1'b0;
        e_bucket = 8'h00;
    endtask

    // Called one time unit after a rising edge. Applies inputs, checks all
    // outputs mid-cycle, then advances the model across the next edge.
    task automatic tick(input logic pv, input logic [7:0] pb, input logic pr);
        bit acc;
        bit found;
        push_valid  = pv;
        push_bucket = pb;
        pop_req     = pr;
        #2;
        chk("push_ready", 16'(push_ready), 16'(mcnt[pb] != 255));
        chk("pop_ready",  16'(pop_ready),  16'(mphase == 0));
        chk("pop_valid",  16'(pop_valid),  16'(e_valid));
        chk("pop_empty",  16'(pop_empty),  16'(e_empty));
        chk("pop_bucket", 16'(pop_bucket), 16'(e_bucket));
        chk("total",      total,           16'(model_total()));
        chk("empty",      16'(empty),      16'(model_total() == 0));
        if (pop_valid) got.push_back(pop_bucket);
        acc = pv && (mcnt[pb] != 255);
        @(posedge clk);
        e_valid  = 1'b0;
        e_empty  = 1'b0;
        e_bucket = 8'h00;
        case (mphase)
            2: begin
                e_valid = 1'b1;
                found   = 1'b0;
                if (snap_any) begin
                    for (int b = snap_g * 16; b < snap_g * 16 + 16; b++) begin
                        if (!found && mcnt[b] > 0) begin
                            found    = 1'b1;
                            mcnt[b]--;
                            e_bucket = 8'(b);
                        end
                    end
                end
                e_empty = !found;
                mphase  = 0;
            end
            1: begin
                snap_any = 1'b0;
                for (int b = 0; b < 256; b++) begin
                    if (!snap_any && mcnt[b] > 0) begin
                        snap_any = 1'b1;
                        snap_g   = b / 16;
                    end
                end
                mphase = 2;
            end
            default: if (pr) mphase = 1;
        endcase
        if (acc) mcnt[pb]++;
        #1;
    endtask

    task automatic do_reset();
        push_valid  = 1'b0;
        push_bucket = 8'h00;
        pop_req     = 1'b0;
        arst_n      = 1'b0;
        model_reset();
        #2;
        chk("rst_pop_valid",  16'(pop_valid),  16'd0);
        chk("rst_pop_empty",  16'(pop_empty),  16'd0);
        chk("rst_pop_bucket", 16'(pop_bucket), 16'd0);
        chk("rst_total",      total,           16'd0);
        chk("rst_empty",      16'(empty),      16'd1);
        chk("rst_pop_ready",  16'(pop_ready),  16'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_seq();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        do_reset();

        // Pop on an empty structure
        got.delete();
        pop_seq();
        tick(1'b0, 8'h00, 1'b0);
        chk("empty_pop_n", 16'(got.size()), 16'd1);

        // Ordering of three pops
        tick(1'b1, 8'h35, 1'b0);
        tick(1'b1, 8'h12, 1'b0);
        tick(1'b1, 8'h12, 1'b0);
        got.delete();
        repeat (3) pop_seq();
        tick(1'b0, 8'h00, 1'b0);
        chk("order_n",  16'(got.size()), 16'd3);
        chk("order_0",  16'(got[0]), 16'h12);
        chk("order_1",  16'(got[1]), 16'h12);
        chk("order_2",  16'(got[2]), 16'h35);
        chk("order_empty", 16'(empty), 16'd1);

        // Saturation of bucket 0x40
        repeat (255) tick(1'b1, 8'h40, 1'b0);
        chk("sat_ready_40", 16'(push_ready), 16'd0);
        tick(1'b1, 8'h40, 1'b0);
        tick(1'b1, 8'h41, 1'b0);
        got.delete();
        pop_seq();
        tick(1'b1, 8'h40, 1'b0);
        chk("sat_pop", 16'(got[0]), 16'h40);
        chk("sat_total", total, 16'd256);
        do_reset();

        // Push into the popped bucket during COMMIT
        tick(1'b1, 8'h20, 1'b0);
        got.delete();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h20, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("coll_bucket", 16'(got[0]), 16'h20);
        chk("coll_total",  total, 16'd1);
        pop_seq();
        tick(1'b0, 8'h00, 1'b0);
        chk("coll_again", 16'(got[1]), 16'h20);
        do_reset();

        // Lower-group push during SEARCH is not seen by that pop
        tick(1'b1, 8'h80, 1'b0);
        got.delete();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h05, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        pop_seq();
        tick(1'b0, 8'h00, 1'b0);
        chk("search_0", 16'(got[0]), 16'h80);
        chk("search_1", 16'(got[1]), 16'h05);
        do_reset();

        // Reset during SEARCH drops the pending pop
        tick(1'b1, 8'h77, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        got.delete();
        do_reset();
        repeat (4) tick(1'b0, 8'h00, 1'b0);
        chk("rstmid_nopop", 16'(got.size()), 16'd0);

        // Randomized traffic over a small set of colliding buckets
        repeat (600) begin
            tick(($urandom_range(0, 9) < 4), 8'($urandom_range(0, 255)) & 8'h33,
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
